// File: rtl/currentmirror_seq.sv
// currentmirror_seq
//   Power-up sequencer for a multi-channel current mirror. Enables the
//   reference leg, lets it settle, checks the leg status, then ramps each
//   output channel's leg count one LSB at a time toward its target code.
//   Any later loss of leg regulation forces the sticky FAULT state.
//
// Ports
//   clk                  in   sole clock, rising edge
//   rst                  in   asynchronous active-high reset
//   enable_currentmirror in   block enable (synchronous)
//   ten                  in   test mode: 1-cycle settle, ramp step every cycle
//   gain_cfg             in   target leg count, channel k at [k*GBITS +: GBITS]
//   pok, nok             in   raw asynchronous leg status, 1 = in regulation
//   en, enb              out  reference-leg enable and its complement
//   gain_cur             out  applied leg count, same packing as gain_cfg
//   ok_currentmirror     out  mirror up and valid
//   fault                out  sticky fault flag
//   state                out  FSM state encoding
//
// state    | meaning
// ---------+-------------------------------------------------------------
// OFF      | leg disabled, all channels at 0
// REF_ON   | leg enabled, one cycle to arm the settle counter
// SETTLE   | waiting for the leg to settle, channels held at 0
// RAMP     | stepping channels toward gain_cfg
// ON       | all channels matched once; keeps tracking gain_cfg changes
// FAULT    | leg lost regulation; everything off until enable drops

module currentmirror_seq #(
  parameter int NCH        = 4,
  parameter int GBITS      = 4,
  parameter int SETTLE_CYC = 64,
  parameter int DEB_CYC    = 8,
  parameter int RAMP_DIV   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable_currentmirror,
  input  logic                 ten,
  input  logic [NCH*GBITS-1:0] gain_cfg,
  input  logic                 pok,
  input  logic                 nok,
  output logic                 en,
  output logic                 enb,
  output logic [NCH*GBITS-1:0] gain_cur,
  output logic                 ok_currentmirror,
  output logic                 fault,
  output logic [2:0]           state
);

  typedef enum logic [2:0] {
    S_OFF    = 3'd0,
    S_REF_ON = 3'd1,
    S_SETTLE = 3'd2,
    S_RAMP   = 3'd3,
    S_ON     = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  localparam int DW = $clog2(DEB_CYC + 1);
  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam int RW = $clog2(RAMP_DIV + 1);

  localparam logic [DW-1:0] DEB_LAST    = DW'(DEB_CYC - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [RW-1:0] DIV_LAST    = RW'(RAMP_DIV - 1);

  // ---------------------------------------------------------------------
  // Status synchronizers and debouncers; bit 0 = pok, bit 1 = nok
  // ---------------------------------------------------------------------
  logic [1:0]          w_raw;
  logic [1:0]          r_sync1;
  logic [1:0]          r_sync2;
  logic [1:0]          r_db;
  logic [1:0][DW-1:0]  r_deb_cnt;
  logic                w_refs_ok;

  assign w_raw     = {nok, pok};
  assign w_refs_ok = &r_db;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_db      <= '0;
      r_deb_cnt <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < 2; i++) begin
        // The count only advances while the synchronized value disagrees
        // with the debounced one; any agreement restarts the window.
        if (r_sync2[i] == r_db[i]) begin
          r_deb_cnt[i] <= '0;
        end else if (r_deb_cnt[i] == DEB_LAST) begin
          r_db[i]      <= r_sync2[i];
          r_deb_cnt[i] <= '0;
        end else begin
          r_deb_cnt[i] <= r_deb_cnt[i] + DW'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Per-channel one-step-toward-target value
  // ---------------------------------------------------------------------
  logic [NCH*GBITS-1:0] r_gain;
  logic [NCH*GBITS-1:0] w_stepped;
  logic                 w_match;

  assign w_match = (r_gain == gain_cfg);

  for (genvar k = 0; k < NCH; k++) begin : g_step
    logic [GBITS-1:0] w_cur;
    logic [GBITS-1:0] w_tgt;
    assign w_cur = r_gain[k*GBITS +: GBITS];
    assign w_tgt = gain_cfg[k*GBITS +: GBITS];
    assign w_stepped[k*GBITS +: GBITS] = (w_cur < w_tgt) ? w_cur + GBITS'(1) :
                                         (w_cur > w_tgt) ? w_cur - GBITS'(1) :
                                                           w_cur;
  end

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  state_t               r_state;
  state_t               w_nxt_state;
  logic [SW-1:0]        r_settle;
  logic [SW-1:0]        w_nxt_settle;
  logic [RW-1:0]        r_div;
  logic [RW-1:0]        w_nxt_div;
  logic [NCH*GBITS-1:0] w_nxt_gain;
  logic                 r_en;
  logic                 r_ok;
  logic                 r_fault;

  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_settle = r_settle;
    w_nxt_div    = '0;
    w_nxt_gain   = '0;

    case (r_state)
      S_OFF: begin
        if (enable_currentmirror) w_nxt_state = S_REF_ON;
      end
      S_REF_ON: begin
        w_nxt_settle = '0;
        w_nxt_state  = S_SETTLE;
      end
      S_SETTLE: begin
        if (ten || (r_settle == SETTLE_LAST)) begin
          w_nxt_state = w_refs_ok ? S_RAMP : S_FAULT;
        end else begin
          w_nxt_settle = r_settle + SW'(1);
        end
      end
      S_RAMP, S_ON: begin
        if (!w_refs_ok) begin
          w_nxt_state = S_FAULT;
        end else begin
          w_nxt_gain = r_gain;
          // The match is judged on the registered count, so ON follows
          // the cycle in which every channel already sits on its target.
          if ((r_state == S_RAMP) && w_match) w_nxt_state = S_ON;
          if (ten || (r_div == DIV_LAST)) begin
            w_nxt_gain = w_stepped;
          end else begin
            w_nxt_div = r_div + RW'(1);
          end
        end
      end
      S_FAULT: begin
        w_nxt_state = S_FAULT;
      end
      default: begin
        w_nxt_state = S_OFF;
      end
    endcase

    // Disable wins over everything else, including fault detection.
    if (!enable_currentmirror) begin
      w_nxt_state = S_OFF;
      w_nxt_gain  = '0;
      w_nxt_div   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_OFF;
      r_settle <= '0;
      r_div    <= '0;
      r_gain   <= '0;
      r_en     <= 1'b0;
      r_ok     <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      r_state  <= w_nxt_state;
      r_settle <= w_nxt_settle;
      r_div    <= w_nxt_div;
      r_gain   <= w_nxt_gain;
      r_en     <= (w_nxt_state == S_REF_ON) || (w_nxt_state == S_SETTLE) ||
                  (w_nxt_state == S_RAMP)   || (w_nxt_state == S_ON);
      r_ok     <= (w_nxt_state == S_ON);
      r_fault  <= (w_nxt_state == S_FAULT);
    end
  end

  assign state            = r_state;
  assign en               = r_en;
  assign enb              = ~r_en;
  assign gain_cur         = r_gain;
  assign ok_currentmirror = r_ok;
  assign fault            = r_fault;

endmodule

// File: tb/tb_currentmirror_seq.sv
// Testbench for currentmirror_seq (NCH=2, GBITS=4, SETTLE_CYC=16, DEB_CYC=4,
// RAMP_DIV=2). Expected per-cycle output snapshots are queued as stimulus is
// driven and compared shortly after the following rising edge.

module tb_currentmirror_seq;

  localparam logic [2:0] ST_OFF  = 3'd0;
  localparam logic [2:0] ST_REF  = 3'd1;
  localparam logic [2:0] ST_SET  = 3'd2;
  localparam logic [2:0] ST_RAMP = 3'd3;
  localparam logic [2:0] ST_ON   = 3'd4;
  localparam logic [2:0] ST_FLT  = 3'd5;

  logic       clk;
  logic       rst;
  logic       enable_currentmirror;
  logic       ten;
  logic [7:0] gain_cfg;
  logic       pok;
  logic       nok;
  logic       en;
  logic       enb;
  logic [7:0] gain_cur;
  logic       ok_currentmirror;
  logic       fault;
  logic [2:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string      tag;
    logic [14:0] val;
  } exp_t;

  exp_t sb_q[$];

  currentmirror_seq #(
    .NCH       (2),
    .GBITS     (4),
    .SETTLE_CYC(16),
    .DEB_CYC   (4),
    .RAMP_DIV  (2)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .enable_currentmirror(enable_currentmirror),
    .ten                 (ten),
    .gain_cfg            (gain_cfg),
    .pok                 (pok),
    .nok                 (nok),
    .en                  (en),
    .enb                 (enb),
    .gain_cur            (gain_cur),
    .ok_currentmirror    (ok_currentmirror),
    .fault               (fault),
    .state               (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // {state, gain_cur, en, enb, ok, fault}; en/ok/fault follow from the state.
  function automatic logic [14:0] pack(input logic [2:0] st, input int g0, input int g1);
    logic e;
    e = (st == ST_REF) || (st == ST_SET) || (st == ST_RAMP) || (st == ST_ON);
    return {st, 4'(g1), 4'(g0), e, ~e, (st == ST_ON), (st == ST_FLT)};
  endfunction

  function automatic logic [14:0] obs_vec();
    return {state, gain_cur, en, enb, ok_currentmirror, fault};
  endfunction

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq(e.tag, 32'(obs_vec()), 32'(e.val));
    end
  end

  // Queue the snapshot expected after the next rising edge, then advance.
  task automatic exp_cyc(input string tag, input logic [2:0] st, input int g0, input int g1);
    exp_t e;
    e.tag = tag;
    e.val = pack(st, g0, g1);
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  // Enable from OFF and follow REF_ON, SETTLE and the ramp up to ON
  // (or only up to ramp snapshot stop_j).
  task automatic run_startup(input int t0, input int t1, input bit tm, input int stop_j);
    int dv;
    int mx;
    int len;
    int g0;
    int g1;
    ten                  = tm;
    gain_cfg             = {4'(t1), 4'(t0)};
    enable_currentmirror = 1'b1;
    exp_cyc("ref_on", ST_REF, 0, 0);
    repeat (tm ? 1 : 16) exp_cyc("settle", ST_SET, 0, 0);
    dv  = tm ? 1 : 2;
    mx  = (t0 > t1) ? t0 : t1;
    len = mx * dv;
    for (int j = 0; (j <= len + 1) && (j <= stop_j); j++) begin
      g0 = ((j / dv) < t0) ? (j / dv) : t0;
      g1 = ((j / dv) < t1) ? (j / dv) : t1;
      exp_cyc("ramp", (j == len + 1) ? ST_ON : ST_RAMP, g0, g1);
    end
  endtask

  initial begin
    int prev;
    int nchg;
    int ok_low;
    int t_chg[4];
    int v_chg[4];

    rst                  = 1'b1;
    enable_currentmirror = 1'b1;
    ten                  = 1'b0;
    pok                  = 1'b1;
    nok                  = 1'b1;
    gain_cfg             = '0;

    #3 check_eq("reset_async", 32'(obs_vec()), 32'(pack(ST_OFF, 0, 0)));
    repeat (3) @(negedge clk);
    check_eq("reset_held", 32'(obs_vec()), 32'(pack(ST_OFF, 0, 0)));

    // Startup straight out of reset: first edge already moves to REF_ON.
    rst = 1'b0;
    run_startup(5, 3, 1'b0, 99);
    repeat (2) exp_cyc("on_hold", ST_ON, 5, 3);

    // Short pok glitch is filtered; a long one faults 2+4 cycles after the drop.
    pok = 1'b0;
    repeat (3) exp_cyc("glitch_short", ST_ON, 5, 3);
    pok = 1'b1;
    repeat (8) exp_cyc("glitch_recover", ST_ON, 5, 3);
    pok = 1'b0;
    repeat (6) exp_cyc("glitch_long_pre", ST_ON, 5, 3);
    pok = 1'b1;
    exp_cyc("glitch_long_fault", ST_FLT, 0, 0);
    exp_cyc("fault_sticky", ST_FLT, 0, 0);
    enable_currentmirror = 1'b0;
    exp_cyc("fault_clear", ST_OFF, 0, 0);
    exp_cyc("off_idle", ST_OFF, 0, 0);

    // Retarget ch0 5 -> 2 while ON.
    run_startup(5, 3, 1'b0, 99);
    gain_cfg = {4'd3, 4'd2};
    prev     = 5;
    nchg     = 0;
    ok_low   = 0;
    for (int i = 0; i < 4; i++) begin
      t_chg[i] = -100;
      v_chg[i] = -1;
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if ((ok_currentmirror !== 1'b1) || (state !== ST_ON)) ok_low++;
      if (int'(gain_cur[3:0]) != prev) begin
        if (nchg < 4) begin
          t_chg[nchg] = i;
          v_chg[nchg] = int'(gain_cur[3:0]);
        end
        nchg++;
        prev = int'(gain_cur[3:0]);
      end
    end
    check_eq("retarget_nsteps", 32'(nchg), 32'd3);
    check_eq("retarget_v0", 32'(v_chg[0]), 32'd4);
    check_eq("retarget_v1", 32'(v_chg[1]), 32'd3);
    check_eq("retarget_v2", 32'(v_chg[2]), 32'd2);
    check_eq("retarget_gap01", 32'(t_chg[1] - t_chg[0]), 32'd2);
    check_eq("retarget_gap12", 32'(t_chg[2] - t_chg[1]), 32'd2);
    check_eq("retarget_stays_on", 32'(ok_low), 32'd0);
    check_eq("retarget_ch1", 32'(gain_cur[7:4]), 32'd3);
    enable_currentmirror = 1'b0;
    exp_cyc("disable_on", ST_OFF, 0, 0);

    // Test mode: 1-cycle settle, one step per cycle.
    run_startup(5, 0, 1'b1, 99);
    ten                  = 1'b0;
    enable_currentmirror = 1'b0;
    exp_cyc("disable_tm", ST_OFF, 0, 0);

    // All-zero target: RAMP hands over to ON right away.
    run_startup(0, 0, 1'b0, 99);
    enable_currentmirror = 1'b0;
    exp_cyc("disable_zero", ST_OFF, 0, 0);

    // Settle failure with nok held low.
    nok                  = 1'b0;
    enable_currentmirror = 1'b1;
    exp_cyc("sf_ref_on", ST_REF, 0, 0);
    repeat (16) exp_cyc("sf_settle", ST_SET, 0, 0);
    exp_cyc("sf_fault", ST_FLT, 0, 0);
    exp_cyc("sf_fault_hold", ST_FLT, 0, 0);
    enable_currentmirror = 1'b0;
    exp_cyc("sf_off", ST_OFF, 0, 0);
    nok = 1'b1;

    // Enable dropped mid-RAMP.
    run_startup(5, 3, 1'b0, 5);
    enable_currentmirror = 1'b0;
    exp_cyc("ramp_disable", ST_OFF, 0, 0);

    // Reset asserted mid-RAMP, checked before any clock edge.
    run_startup(5, 3, 1'b0, 5);
    #2 rst = 1'b1;
    #1 check_eq("ramp_rst_async", 32'(obs_vec()), 32'(pack(ST_OFF, 0, 0)));
    @(negedge clk);
    enable_currentmirror = 1'b0;
    rst                  = 1'b0;
    exp_cyc("post_rst", ST_OFF, 0, 0);

    check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
